// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared sizes, FSM state type and round-robin winner search for mux_rr_arbiter
package mux_arb_pkg;
    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Lowest index at or after ptr+1 wins; scanning backwards lets the nearest hit overwrite farther ones.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req, input logic [SEL_W-1:0] ptr);
        pick_t p;
        logic [SEL_W-1:0] idx;
        p = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = ptr + SEL_W'(i);
            if (req[idx]) begin
                p.found = 1'b1;
                p.idx   = idx;
            end
        end
        return p;
    endfunction
endpackage

// File: rtl/mux_4x1.sv
// mux_4x1: combinational 4:1 bit mux, sel 0 picks din[3] and sel 3 picks din[0]
module mux_4x1
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] din,
    input  logic [SEL_W-1:0] sel,
    output logic             y
);
    assign y = din[SEL_W'(N_REQ - 1) - sel];
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin owner of a shared mux_4x1 bit; define ARB_LOCK_EN to add lock[3:0] burst override
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] din,
`ifdef ARB_LOCK_EN
    input  logic [N_REQ-1:0] lock,
`endif
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy
);
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] ptr_q, ptr_d, sel_q, sel_d, own;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             dout_q, dout_d, dv_q, dv_d, raw, locked, lim, fin;
    pick_t            pick;

    mux_4x1 u_mux (.din(din), .sel(sel_q), .y(raw));

    assign own = SEL_W'(N_REQ - 1) - sel_q;
    assign lim = cnt_q == CNT_MAX;
`ifdef ARB_LOCK_EN
    assign locked = lock[own];
`else
    assign locked = 1'b0;
`endif

    // State, burst counter, last-owner pointer and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= SEL_W'(N_REQ - 1);
            gnt_q   <= '0;
            sel_q   <= '0;
            dout_q  <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
        end
    end

    // Next state: transfer the owner's bit, end the grant on release or burst limit, rearbitrate without a bubble.
    always_comb begin
        pick    = rr_pick(req, state_q == GRANT ? own : ptr_q);
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        dout_d  = dout_q;
        dv_d    = 1'b0;
        fin     = 1'b0;
        if (state_q == GRANT) begin
            if (req[own]) begin
                dout_d = raw;
                dv_d   = 1'b1;
                cnt_d  = lim ? cnt_q : cnt_q + 1'b1;
            end
            fin = !req[own] || (lim && !locked);
            if (fin) ptr_d = own;
        end
        if (state_q == IDLE || fin) begin
            state_d = pick.found ? GRANT : IDLE;
            gnt_d   = pick.found ? N_REQ'(1) << pick.idx : '0;
            sel_d   = pick.found ? SEL_W'(N_REQ - 1) - pick.idx : sel_q;
            cnt_d   = '0;
        end
    end

    // Outputs come straight from registers; busy reflects the GRANT state.
    always_comb begin
        gnt        = gnt_q;
        sel        = sel_q;
        dout       = dout_q;
        dout_valid = dv_q;
        busy       = state_q == GRANT;
    end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: vector table, directed corner sequences and random traffic against a reference model
module tb_mux_rr_arbiter;
    localparam int MAX_BURST = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'hF, din = 4'h0, lock = 4'h0;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       dout, dout_valid, busy;

    int n_chk = 0, n_fail = 0;

    int         m_own, m_cnt, m_last;
    logic [3:0] e_gnt;
    logic [1:0] e_sel;
    logic       e_dout, e_dv, e_busy;

    typedef struct {
        logic       rst_n;
        logic [3:0] req, din, gnt;
        logic [1:0] sel;
        logic       dv, dout, busy;
    } vec_t;
    vec_t tbl[4];

    mux_rr_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .din(din),
`ifdef ARB_LOCK_EN
        .lock(lock),
`endif
        .gnt(gnt), .sel(sel), .dout(dout), .dout_valid(dout_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [3:0] act, logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int rr(logic [3:0] r, int from);
        for (int k = 1; k <= 4; k++)
            if (r[(from + k) % 4]) return (from + k) % 4;
        return -1;
    endfunction

    // Reference: owner id, count of transferred bits in this grant, last owner id.
    task automatic model_step();
        int o;
        if (!rst_n) begin
            m_own = -1; m_cnt = 0; m_last = 3;
            e_sel = 2'd0; e_dout = 1'b0; e_dv = 1'b0;
        end else if (m_own < 0) begin
            m_own = rr(req, m_last);
            m_cnt = 0;
            e_dv  = 1'b0;
        end else begin
            o    = m_own;
            e_dv = req[o];
            if (req[o]) begin
                e_dout = din[o];
                m_cnt++;
            end
            if (!req[o] || (m_cnt >= MAX_BURST && !lock[o])) begin
                m_last = o;
                m_own  = rr(req, o);
                m_cnt  = 0;
            end
        end
        if (m_own >= 0) e_sel = 2'(3 - m_own);
        e_gnt  = (m_own < 0) ? 4'h0 : 4'(1 << m_own);
        e_busy = m_own >= 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("gnt", gnt, e_gnt);
        chk("sel", {2'b0, sel}, {2'b0, e_sel});
        chk("dout_valid", {3'b0, dout_valid}, {3'b0, e_dv});
        chk("dout", {3'b0, dout}, {3'b0, e_dout});
        chk("busy", {3'b0, busy}, {3'b0, e_busy});
    endtask

    initial begin
        tbl[0] = '{1'b0, 4'hF, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 4'hF, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 4'h4, 4'h4, 4'h4, 2'd1, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 4'h4, 4'h4, 4'h4, 2'd1, 1'b1, 1'b1, 1'b1};

        for (int i = 0; i < 4; i++) begin
            rst_n = tbl[i].rst_n; req = tbl[i].req; din = tbl[i].din;
            cycle();
            chk("tbl_gnt", gnt, tbl[i].gnt);
            chk("tbl_sel", {2'b0, sel}, {2'b0, tbl[i].sel});
            chk("tbl_dv", {3'b0, dout_valid}, {3'b0, tbl[i].dv});
            chk("tbl_dout", {3'b0, dout}, {3'b0, tbl[i].dout});
            chk("tbl_busy", {3'b0, busy}, {3'b0, tbl[i].busy});
        end

        for (int i = 0; i < 20; i++) begin
            cycle();
            chk("regrant_gnt", gnt, 4'h4);
            chk("regrant_dv", {3'b0, dout_valid}, 4'h1);
        end

        rst_n = 1'b0; cycle();
        rst_n = 1'b1; req = 4'hF;
        for (int i = 0; i < 41; i++) begin
            din = 4'($urandom);
            cycle();
            chk("rr_order", gnt, 4'(1 << ((i / 8) % 4)));
            if (i > 0) chk("rr_no_bubble", {3'b0, dout_valid}, 4'h1);
        end

        rst_n = 1'b0; cycle();
        rst_n = 1'b1; req = 4'b1010; cycle();
        chk("early_gnt1", gnt, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            din = 4'($urandom); cycle();
            chk("early_dv", {3'b0, dout_valid}, 4'h1);
        end
        req = 4'b1000; cycle();
        chk("early_gnt3", gnt, 4'b1000);
        chk("early_gap", {3'b0, dout_valid}, 4'h0);
        cycle();
        chk("early_resume", {3'b0, dout_valid}, 4'h1);

        rst_n = 1'b0; cycle();
        rst_n = 1'b1; req = 4'b0100; cycle();
        chk("mid_gnt2", gnt, 4'b0100);
        for (int i = 0; i < 3; i++) cycle();
        rst_n = 1'b0; cycle();
        chk("mid_rst_gnt", gnt, 4'h0);
        chk("mid_rst_sel", {2'b0, sel}, 4'h0);
        chk("mid_rst_dv", {3'b0, dout_valid}, 4'h0);
        chk("mid_rst_busy", {3'b0, busy}, 4'h0);
        chk("mid_rst_dout", {3'b0, dout}, 4'h0);
        rst_n = 1'b1; req = 4'hF; cycle();
        chk("mid_first", gnt, 4'b0001);

`ifdef ARB_LOCK_EN
        rst_n = 1'b0; cycle();
        rst_n = 1'b1; lock = 4'b0001; req = 4'b0011; cycle();
        chk("lock_gnt0", gnt, 4'b0001);
        for (int i = 0; i < 20; i++) begin
            din = 4'($urandom); cycle();
            chk("lock_hold", gnt, 4'b0001);
            chk("lock_dv", {3'b0, dout_valid}, 4'h1);
        end
        req = 4'b0010; cycle();
        chk("lock_next", gnt, 4'b0010);
        lock = 4'h0;
`endif

        for (int i = 0; i < 3000; i++) begin
            rst_n = $urandom_range(99) != 0;
            if ($urandom_range(3) == 0) req = 4'($urandom);
            din = 4'($urandom);
`ifdef ARB_LOCK_EN
            if ($urandom_range(7) == 0) lock = 4'($urandom);
`endif
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
